// File: rtl/store_monitor.sv
// Watches processor data-memory stores, decides PASS/FAIL/TOUT for a test run,
// and keeps a first-word-fall-through log of every store seen while running.
module store_monitor #(
    parameter logic [31:0] PASS_ADR  = 32'd84,
    parameter logic [31:0] PASS_DATA = 32'd7,
    parameter logic [31:0] ALLOW_ADR = 32'd80,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        pop,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic [4:0]  log_count,
    output logic        overflow,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] cycles
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [4:0]  DEPTH_C   = 5'(DEPTH);
    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

    state_t      state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic        done_q, pass_q, fail_q, tout_q;

    // A deciding store beats the timeout; cycles only advances while staying in RUN.
    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        if (state_q == S_RUN) begin
            if (memwrite && dataadr == PASS_ADR && writedata == PASS_DATA)
                state_d = S_PASS;
            else if (memwrite && dataadr != ALLOW_ADR)
                state_d = S_FAIL;
            else if (cycles_q == TOUT_LAST)
                state_d = S_TOUT;
            else
                cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            cycles_q <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            done_q   <= (state_d != S_RUN);
            pass_q   <= (state_d == S_PASS);
            fail_q   <= (state_d == S_FAIL);
            tout_q   <= (state_d == S_TOUT);
        end
    end

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop_ok, full, wr_en;

    assign push   = memwrite && (state_q == S_RUN);
    assign pop_ok = pop && (count_q != 5'd0);
    assign full   = (count_q == DEPTH_C);
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_en  = push && (!full || pop_ok);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (wr_en && !pop_ok)
            count_d = count_q + 5'd1;
        else if (!wr_en && pop_ok)
            count_d = count_q - 5'd1;
        if (push && !wr_en)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= {dataadr, writedata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign log_valid = (count_q != 5'd0);
    assign log_adr   = mem[rd_ptr_q][63:32];
    assign log_data  = mem[rd_ptr_q][31:0];
    assign log_count = count_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = tout_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_monitor;

    localparam int          T_TIMEOUT = 10;
    localparam int          T_DEPTH   = 8;
    localparam logic [31:0] P_ADR     = 32'd84;
    localparam logic [31:0] P_DATA    = 32'd7;
    localparam logic [31:0] A_ADR     = 32'd80;

    localparam int M_RUN  = 0;
    localparam int M_PASS = 1;
    localparam int M_FAIL = 2;
    localparam int M_TOUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        pop = 1'b0;
    logic        log_valid;
    logic [31:0] log_adr, log_data;
    logic [4:0]  log_count;
    logic        overflow, done, pass, fail, timeout;
    logic [31:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_state  = M_RUN;
    int          m_cycles = 0;
    bit          m_ovf    = 1'b0;
    logic [63:0] m_q[$];

    store_monitor #(
        .PASS_ADR (P_ADR),
        .PASS_DATA(P_DATA),
        .ALLOW_ADR(A_ADR),
        .TIMEOUT  (T_TIMEOUT),
        .DEPTH    (T_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .pop      (pop),
        .log_valid(log_valid),
        .log_adr  (log_adr),
        .log_data (log_data),
        .log_count(log_count),
        .overflow (overflow),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .timeout  (timeout),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic mw, input logic [31:0] a,
                                input logic [31:0] d, input logic p);
        bit was_full;
        bit do_pop;
        bit do_push;
        if (r) begin
            m_state  = M_RUN;
            m_cycles = 0;
            m_ovf    = 1'b0;
            m_q.delete();
            return;
        end
        was_full = (m_q.size() == T_DEPTH);
        do_pop   = p && (m_q.size() > 0);
        do_push  = mw && (m_state == M_RUN);
        if (m_state == M_RUN) begin
            if (mw && a == P_ADR && d == P_DATA)      m_state = M_PASS;
            else if (mw && a != A_ADR)                m_state = M_FAIL;
            else if (m_cycles == T_TIMEOUT - 1)       m_state = M_TOUT;
            else                                      m_cycles++;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (was_full && !do_pop) m_ovf = 1'b1;
            else                     m_q.push_back({a, d});
        end
    endtask

    task automatic step(input logic r, input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic p);
        reset = r; memwrite = mw; dataadr = a; writedata = d; pop = p;
        @(posedge clk);
        model_update(r, mw, a, d, p);
        #1;
        $display("[TB] t=%0t rst=%0b wr=%0b adr=%0d data=%0d pop=%0b -> cnt=%0d done=%0b pass=%0b fail=%0b tout=%0b cyc=%0d ovf=%0b",
                 $time, r, mw, a, d, p, log_count, done, pass, fail, timeout, cycles, overflow);
        reset = 1'b0; memwrite = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 32'd99, 32'd1, 1'b1);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {done, pass, fail, timeout}); end
        n_tests++; if (cycles !== 32'd0) begin n_fail++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
        n_tests++; if (log_count !== 5'd0 || log_valid !== 1'b0) begin n_fail++; $display("FAIL reset_log got cnt=%0d valid=%b exp 0/0", log_count, log_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_pass();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd80, 32'd5, 1'b0);
        n_tests++; if (done !== 1'b0 || log_count !== 5'd1) begin n_fail++; $display("FAIL pass_allow got done=%b cnt=%0d exp 0/1", done, log_count); end
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b1100) begin n_fail++; $display("FAIL pass_flags got=%b exp=1100", {done, pass, fail, timeout}); end
        n_tests++; if (cycles !== 32'd1) begin n_fail++; $display("FAIL pass_cycles got=%0d exp=1", cycles); end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        n_tests++; if (cycles !== 32'd1) begin n_fail++; $display("FAIL pass_frozen got=%0d exp=1", cycles); end
        n_tests++; if (log_count !== 5'd2 || log_adr !== 32'd80 || log_data !== 32'd5) begin n_fail++; $display("FAIL pass_head0 got cnt=%0d (%0d,%0d) exp 2 (80,5)", log_count, log_adr, log_data); end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        n_tests++; if (log_count !== 5'd1 || log_adr !== 32'd84 || log_data !== 32'd7) begin n_fail++; $display("FAIL pass_head1 got cnt=%0d (%0d,%0d) exp 1 (84,7)", log_count, log_adr, log_data); end
    endtask

    task automatic test_fail();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd6, 1'b0);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b1010) begin n_fail++; $display("FAIL fail_flags got=%b exp=1010", {done, pass, fail, timeout}); end
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b1010 || log_count !== 5'd1) begin n_fail++; $display("FAIL fail_ignore got=%b cnt=%0d exp 1010 cnt=1", {done, pass, fail, timeout}, log_count); end
    endtask

    task automatic test_timeout();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < T_TIMEOUT - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        n_tests++; if (timeout !== 1'b0 || cycles !== 32'd9) begin n_fail++; $display("FAIL tout_early got tout=%b cyc=%0d exp 0/9", timeout, cycles); end
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b1001 || cycles !== 32'd9) begin n_fail++; $display("FAIL tout_hit got=%b cyc=%0d exp 1001/9", {done, pass, fail, timeout}, cycles); end
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < T_TIMEOUT - 1; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        n_tests++; if ({done, pass, fail, timeout} !== 4'b1100) begin n_fail++; $display("FAIL tout_prio got=%b exp=1100", {done, pass, fail, timeout}); end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'd80, 32'(i + 1), 1'b0);
        n_tests++; if (log_count !== 5'd8 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_full got cnt=%0d ovf=%b exp 8/1", log_count, overflow); end
        n_tests++; if (log_adr !== 32'd80 || log_data !== 32'd1) begin n_fail++; $display("FAIL ovf_head got (%0d,%0d) exp (80,1)", log_adr, log_data); end
        step(1'b0, 1'b1, 32'd80, 32'd100, 1'b1);
        n_tests++; if (log_count !== 5'd8 || log_data !== 32'd2) begin n_fail++; $display("FAIL ovf_pushpop got cnt=%0d head=%0d exp 8/2", log_count, log_data); end
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        n_tests++; if (log_count !== 5'd1 || log_data !== 32'd100) begin n_fail++; $display("FAIL ovf_tail got cnt=%0d data=%0d exp 1/100", log_count, log_data); end
    endtask

    task automatic test_pop_reset();
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        n_tests++; if (log_count !== 5'd0 || log_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty got cnt=%0d valid=%b exp 0/0", log_count, log_valid); end
        step(1'b0, 1'b1, 32'd80, 32'd1, 1'b0);
        step(1'b0, 1'b1, 32'd80, 32'd2, 1'b0);
        step(1'b0, 1'b1, 32'd84, 32'd7, 1'b0);
        n_tests++; if (log_count !== 5'd3 || pass !== 1'b1) begin n_fail++; $display("FAIL pre_reset got cnt=%0d pass=%b exp 3/1", log_count, pass); end
        step(1'b1, 1'b1, 32'd84, 32'd7, 1'b1);
        n_tests++; if (log_count !== 5'd0 || pass !== 1'b0 || done !== 1'b0 || cycles !== 32'd0) begin n_fail++; $display("FAIL mid_reset got cnt=%0d pass=%b done=%b cyc=%0d exp 0/0/0/0", log_count, pass, done, cycles); end
    endtask

    task automatic test_random();
        logic r, mw, p;
        logic [31:0] a, d;
        int sel;
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 14) == 0);
            mw  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            a   = (sel < 7) ? A_ADR : (sel < 9) ? P_ADR : 32'($urandom_range(0, 255));
            d   = $urandom_range(0, 1) ? P_DATA : 32'($urandom_range(0, 15));
            p   = ($urandom_range(0, 3) == 0);
            step(r, mw, a, d, p);
            n_tests++; if (log_count !== 5'(m_q.size()) || log_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_count i=%0d got cnt=%0d valid=%b exp %0d", i, log_count, log_valid, m_q.size()); end
            if (m_q.size() > 0) begin
                n_tests++; if ({log_adr, log_data} !== m_q[0]) begin n_fail++; $display("FAIL rnd_head i=%0d got (%0d,%0d) exp (%0d,%0d)", i, log_adr, log_data, m_q[0][63:32], m_q[0][31:0]); end
            end
            n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, overflow, m_ovf); end
            n_tests++; if ({done, pass, fail, timeout} !== {m_state != M_RUN, m_state == M_PASS, m_state == M_FAIL, m_state == M_TOUT}) begin n_fail++; $display("FAIL rnd_state i=%0d got=%b exp_state=%0d", i, {done, pass, fail, timeout}, m_state); end
            n_tests++; if (cycles !== 32'(m_cycles)) begin n_fail++; $display("FAIL rnd_cycles i=%0d got=%0d exp=%0d", i, cycles, m_cycles); end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_overflow();
        test_pop_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
